// File: rtl/ctrl_pkg.sv
//------------------------------------------------------------------------------
// ctrl_pkg
//   Shared definitions for the micro-program sequencer: sequencing opcodes,
//   next-address mux select codes and the sequencer state encoding.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package ctrl_pkg;

  // Sequencing field of the microword
  localparam logic [2:0] SEQ_NEXT = 3'd0;
  localparam logic [2:0] SEQ_JUMP = 3'd1;
  localparam logic [2:0] SEQ_BRC  = 3'd2;
  localparam logic [2:0] SEQ_DISP = 3'd3;
  localparam logic [2:0] SEQ_CALL = 3'd4;
  localparam logic [2:0] SEQ_RET  = 3'd5;
  localparam logic [2:0] SEQ_WAIT = 3'd6;
  localparam logic [2:0] SEQ_HALT = 3'd7;

  // Select codes for the external 4:1 next-address mux
  localparam logic [1:0] MUX_SEL_A = 2'd0;  // upc + 1
  localparam logic [1:0] MUX_SEL_B = 2'd1;  // branch / call target
  localparam logic [1:0] MUX_SEL_C = 2'd2;  // dispatch address
  localparam logic [1:0] MUX_SEL_D = 2'd3;  // return-stack top

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_WAIT = 2'd2,
    ST_HALT = 2'd3
  } seq_state_e;

endpackage

`default_nettype wire

// File: rtl/micro_ret_stack.sv
//------------------------------------------------------------------------------
// micro_ret_stack
//   Micro-return stack, DEPTH entries of AW bits. Push on full and pop on
//   empty are ignored here; the caller flags them as errors.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   push_i       write data_i on top (ignored when full)
//   pop_i        discard top entry (ignored when empty)
//   data_i       return address to push
//   top_o        top entry, 0 when empty
//   full_o       DEPTH entries held
//   empty_o      no entries held
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module micro_ret_stack #(
  parameter int AW    = 4,
  parameter int DEPTH = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [AW-1:0] data_i,
  output logic [AW-1:0] top_o,
  output logic          full_o,
  output logic          empty_o
);

  localparam int SPW = $clog2(DEPTH + 1);

  logic [AW-1:0]  mem_q [DEPTH];
  logic [SPW-1:0] sp_q;
  logic [SPW-1:0] top_idx;
  logic           do_push;
  logic           do_pop;

  assign full_o  = (sp_q == SPW'(DEPTH));
  assign empty_o = (sp_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign top_idx = sp_q - 1'b1;

  // Read mux written as a compare loop so sp never needs to index the array
  // with a wider-than-needed value.
  always_comb begin
    top_o = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!empty_o && (top_idx == SPW'(i))) top_o = mem_q[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sp_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (do_push) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (sp_q == SPW'(i)) mem_q[i] <= data_i;
        end
        sp_q <= sp_q + 1'b1;
      end else if (do_pop) begin
        sp_q <= sp_q - 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/micro_sequencer.sv
//------------------------------------------------------------------------------
// micro_sequencer
//   Holds the micro-PC, builds the four next-address candidates, drives the
//   select of the external 4:1 mux and loads the mux output back into upc.
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   start_i        leave IDLE/HALT and begin at address 0
//   seq_op_i       sequencing field of the current microword
//   br_target_i    branch / call target field
//   disp_addr_i    opcode-decoded dispatch address
//   cond_i         branch condition
//   mem_ready_i    memory operation complete
//   next_addr_i    selected next address from the external mux
//   upc_o          current micro-PC
//   cand_a_o..d_o  mux inputs: upc+1, target, dispatch, return-stack top
//   mux_ctrl_o     mux select (0=A 1=B 2=C 3=D)
//   busy_o         RUN or WAIT
//   halted_o       HALT
//   stack_err_o    sticky push-on-full / pop-on-empty flag
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module micro_sequencer
  import ctrl_pkg::*;
#(
  parameter int AW        = 4,
  parameter int RET_DEPTH = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start_i,
  input  logic [2:0]    seq_op_i,
  input  logic [AW-1:0] br_target_i,
  input  logic [AW-1:0] disp_addr_i,
  input  logic          cond_i,
  input  logic          mem_ready_i,
  input  logic [AW-1:0] next_addr_i,
  output logic [AW-1:0] upc_o,
  output logic [AW-1:0] cand_a_o,
  output logic [AW-1:0] cand_b_o,
  output logic [AW-1:0] cand_c_o,
  output logic [AW-1:0] cand_d_o,
  output logic [1:0]    mux_ctrl_o,
  output logic          busy_o,
  output logic          halted_o,
  output logic          stack_err_o
);

  seq_state_e    state_q, state_d;
  logic [AW-1:0] upc_q, upc_d;
  logic          stack_err_q, stack_err_d;
  logic          push, pop, full, empty;
  logic          load, clr;

  micro_ret_stack #(
    .AW    (AW),
    .DEPTH (RET_DEPTH)
  ) u_stack (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .pop_i   (pop),
    .data_i  (cand_a_o),
    .top_o   (cand_d_o),
    .full_o  (full),
    .empty_o (empty)
  );

  assign cand_a_o = upc_q + AW'(1);
  assign cand_b_o = br_target_i;
  assign cand_c_o = disp_addr_i;

  // Select and load decisions depend only on state and microword fields,
  // never on next_addr_i, so the external mux closes no combinational loop.
  always_comb begin
    state_d    = state_q;
    mux_ctrl_o = MUX_SEL_A;
    load       = 1'b0;
    clr        = 1'b0;
    push       = 1'b0;
    pop        = 1'b0;
    unique case (state_q)
      ST_IDLE: if (start_i) state_d = ST_RUN;
      ST_RUN: begin
        case (seq_op_i)
          SEQ_NEXT: load = 1'b1;
          SEQ_JUMP: begin mux_ctrl_o = MUX_SEL_B; load = 1'b1; end
          SEQ_BRC:  begin mux_ctrl_o = cond_i ? MUX_SEL_B : MUX_SEL_A; load = 1'b1; end
          SEQ_DISP: begin mux_ctrl_o = MUX_SEL_C; load = 1'b1; end
          SEQ_CALL: begin mux_ctrl_o = MUX_SEL_B; load = 1'b1; push = 1'b1; end
          SEQ_RET:  begin mux_ctrl_o = MUX_SEL_D; load = 1'b1; pop = 1'b1; end
          SEQ_WAIT: begin
            if (mem_ready_i) load = 1'b1;
            else             state_d = ST_WAIT;
          end
          default:  state_d = ST_HALT;
        endcase
      end
      ST_WAIT: begin
        if (mem_ready_i) begin
          load    = 1'b1;
          state_d = ST_RUN;
        end
      end
      default: begin
        if (start_i) begin
          clr     = 1'b1;
          state_d = ST_RUN;
        end
      end
    endcase
  end

  always_comb begin
    upc_d = upc_q;
    if (clr)       upc_d = '0;
    else if (load) upc_d = next_addr_i;
  end

  assign stack_err_d = stack_err_q | (push && full) | (pop && empty);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      upc_q       <= '0;
      stack_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      upc_q       <= upc_d;
      stack_err_q <= stack_err_d;
    end
  end

  assign upc_o       = upc_q;
  assign busy_o      = (state_q == ST_RUN) || (state_q == ST_WAIT);
  assign halted_o    = (state_q == ST_HALT);
  assign stack_err_o = stack_err_q;

endmodule

`default_nettype wire

// File: tb/tb_micro_sequencer.sv
//------------------------------------------------------------------------------
// tb_micro_sequencer
//   Self-checking bench: models the external 4:1 mux, drives microword
//   fields each cycle and checks upc against a queue of expected addresses.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_micro_sequencer;

  localparam logic [2:0] NX = 3'd0, JP = 3'd1, BR = 3'd2, DS = 3'd3;
  localparam logic [2:0] CL = 3'd4, RT = 3'd5, WT = 3'd6, HL = 3'd7;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [2:0] seq_op = 3'd0;
  logic [3:0] br_target = 4'd0;
  logic [3:0] disp_addr = 4'd0;
  logic       cond = 1'b0;
  logic       mem_ready = 1'b0;
  logic [3:0] next_addr;
  logic [3:0] upc, cand_a, cand_b, cand_c, cand_d;
  logic [1:0] mux_ctrl;
  logic       busy, halted, stack_err;

  int         n_checks = 0;
  int         n_fail = 0;
  logic [3:0] exp_q [$];
  logic [3:0] exp;

  always #5 clk = ~clk;

  // External next-address mux
  always_comb begin
    case (mux_ctrl)
      2'd0:    next_addr = cand_a;
      2'd1:    next_addr = cand_b;
      2'd2:    next_addr = cand_c;
      default: next_addr = cand_d;
    endcase
  end

  micro_sequencer #(.AW(4), .RET_DEPTH(2)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_i     (start),
    .seq_op_i    (seq_op),
    .br_target_i (br_target),
    .disp_addr_i (disp_addr),
    .cond_i      (cond),
    .mem_ready_i (mem_ready),
    .next_addr_i (next_addr),
    .upc_o       (upc),
    .cand_a_o    (cand_a),
    .cand_b_o    (cand_b),
    .cand_c_o    (cand_c),
    .cand_d_o    (cand_d),
    .mux_ctrl_o  (mux_ctrl),
    .busy_o      (busy),
    .halted_o    (halted),
    .stack_err_o (stack_err)
  );

  task automatic drive(input logic [2:0] op, input logic [3:0] tgt, input logic c,
                       input logic mem, input logic st);
    @(negedge clk);
    seq_op = op; br_target = tgt; cond = c; mem_ready = mem; start = st;
    #1;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    @(negedge clk);
    rst_n = 1'b0; start = 1'b0; seq_op = NX; mem_ready = 1'b0; cond = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    do_reset();
    #1;
    n_checks++;
    if (upc !== 4'd0 || busy !== 1'b0 || halted !== 1'b0 || stack_err !== 1'b0 || mux_ctrl !== 2'd0) begin
      n_fail++;
      $display("FAIL reset: upc=%0d busy=%b halted=%b err=%b ctrl=%0d, want 0 0 0 0 0", upc, busy, halted, stack_err, mux_ctrl);
    end
  endtask

  task automatic test_next;
    drive(NX, 4'd0, 1'b0, 1'b0, 1'b1);
    exp_q.push_back(4'd0);
    tick();
    exp = exp_q.pop_front();
    n_checks++;
    if (upc !== exp || busy !== 1'b1) begin
      n_fail++; $display("FAIL start: upc=%0d busy=%b, want %0d 1", upc, busy, exp);
    end
    for (int i = 1; i <= 5; i++) begin
      drive(NX, 4'd0, 1'b0, 1'b0, 1'b0);
      n_checks++;
      if (mux_ctrl !== 2'd0) begin n_fail++; $display("FAIL next_ctrl: got %0d want 0", mux_ctrl); end
      exp_q.push_back(4'(i));
      tick();
      exp = exp_q.pop_front();
      n_checks++;
      if (upc !== exp || busy !== 1'b1) begin
        n_fail++; $display("FAIL next_upc: upc=%0d busy=%b, want %0d 1", upc, busy, exp);
      end
    end
  endtask

  task automatic test_branch;
    logic [2:0] ops  [6] = '{JP, BR, JP, BR, DS, JP};
    logic [3:0] tgts [6] = '{4'd3, 4'd9, 4'd3, 4'd9, 4'd0, 4'd2};
    logic       cnds [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [1:0] ctl  [6] = '{2'd1, 2'd1, 2'd1, 2'd0, 2'd2, 2'd1};
    logic [3:0] nxt  [6] = '{4'd3, 4'd9, 4'd3, 4'd4, 4'd11, 4'd2};
    disp_addr = 4'd11;
    for (int i = 0; i < 6; i++) begin
      drive(ops[i], tgts[i], cnds[i], 1'b0, 1'b0);
      n_checks++;
      if (mux_ctrl !== ctl[i]) begin n_fail++; $display("FAIL branch_ctrl[%0d]: got %0d want %0d", i, mux_ctrl, ctl[i]); end
      exp_q.push_back(nxt[i]);
      tick();
      exp = exp_q.pop_front();
      n_checks++;
      if (upc !== exp) begin n_fail++; $display("FAIL branch_upc[%0d]: got %0d want %0d", i, upc, exp); end
    end
  endtask

  task automatic test_call_ret;
    // upc = 2 here
    drive(CL, 4'd8, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (mux_ctrl !== 2'd1) begin n_fail++; $display("FAIL call_ctrl: got %0d want 1", mux_ctrl); end
    exp_q.push_back(4'd8);
    tick();
    exp = exp_q.pop_front();
    n_checks++;
    if (upc !== exp) begin n_fail++; $display("FAIL call_upc: got %0d want %0d", upc, exp); end
    drive(RT, 4'd0, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (cand_d !== 4'd3 || mux_ctrl !== 2'd3) begin
      n_fail++; $display("FAIL ret_cand: cand_d=%0d ctrl=%0d, want 3 3", cand_d, mux_ctrl);
    end
    exp_q.push_back(4'd3);
    tick();
    exp = exp_q.pop_front();
    n_checks++;
    if (upc !== exp || stack_err !== 1'b0) begin
      n_fail++; $display("FAIL ret_upc: upc=%0d err=%b, want %0d 0", upc, stack_err, exp);
    end
  endtask

  task automatic test_wait;
    logic       mems [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    logic [3:0] nxt  [4] = '{4'd5, 4'd5, 4'd5, 4'd6};
    drive(JP, 4'd5, 1'b0, 1'b0, 1'b0);
    tick();
    for (int i = 0; i < 4; i++) begin
      drive(WT, 4'd0, 1'b0, mems[i], 1'b0);
      n_checks++;
      if (mux_ctrl !== 2'd0 || upc !== 4'd5 || busy !== 1'b1) begin
        n_fail++; $display("FAIL wait_hold[%0d]: ctrl=%0d upc=%0d busy=%b, want 0 5 1", i, mux_ctrl, upc, busy);
      end
      exp_q.push_back(nxt[i]);
      tick();
      exp = exp_q.pop_front();
      n_checks++;
      if (upc !== exp) begin n_fail++; $display("FAIL wait_upc[%0d]: got %0d want %0d", i, upc, exp); end
    end
    // Back in RUN: a NEXT must advance
    drive(NX, 4'd0, 1'b0, 1'b0, 1'b0);
    exp_q.push_back(4'd7);
    tick();
    exp = exp_q.pop_front();
    n_checks++;
    if (upc !== exp) begin n_fail++; $display("FAIL wait_resume: got %0d want %0d", upc, exp); end
  endtask

  task automatic test_stack;
    logic [2:0] ops  [6] = '{CL, CL, CL, RT, RT, RT};
    logic [3:0] tgts [6] = '{4'd4, 4'd8, 4'd12, 4'd0, 4'd0, 4'd0};
    logic [3:0] nxt  [6] = '{4'd4, 4'd8, 4'd12, 4'd5, 4'd1, 4'd0};
    logic       errs [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    // Empty-stack RET from upc 7
    drive(RT, 4'd0, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (cand_d !== 4'd0) begin n_fail++; $display("FAIL empty_cand_d: got %0d want 0", cand_d); end
    exp_q.push_back(4'd0);
    tick();
    exp = exp_q.pop_front();
    n_checks++;
    if (upc !== exp || stack_err !== 1'b1) begin
      n_fail++; $display("FAIL empty_ret: upc=%0d err=%b, want %0d 1", upc, stack_err, exp);
    end
    // Overflow: clear sticky error with a reset first
    do_reset();
    #1;
    n_checks++;
    if (stack_err !== 1'b0) begin n_fail++; $display("FAIL err_clear: got %b want 0", stack_err); end
    drive(NX, 4'd0, 1'b0, 1'b0, 1'b1);
    tick();
    for (int i = 0; i < 6; i++) begin
      drive(ops[i], tgts[i], 1'b0, 1'b0, 1'b0);
      exp_q.push_back(nxt[i]);
      tick();
      exp = exp_q.pop_front();
      n_checks++;
      if (upc !== exp || stack_err !== errs[i]) begin
        n_fail++; $display("FAIL overflow[%0d]: upc=%0d err=%b, want %0d %b", i, upc, stack_err, exp, errs[i]);
      end
    end
  endtask

  task automatic test_wrap_halt;
    drive(JP, 4'd15, 1'b0, 1'b0, 1'b0);
    tick();
    drive(NX, 4'd0, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (cand_a !== 4'd0) begin n_fail++; $display("FAIL wrap_cand_a: got %0d want 0", cand_a); end
    exp_q.push_back(4'd0);
    tick();
    exp = exp_q.pop_front();
    n_checks++;
    if (upc !== exp) begin n_fail++; $display("FAIL wrap_upc: got %0d want %0d", upc, exp); end
    drive(JP, 4'd6, 1'b0, 1'b0, 1'b0);
    tick();
    drive(HL, 4'd0, 1'b0, 1'b0, 1'b0);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(JP, 4'd9, 1'b0, 1'b1, 1'b0);
      n_checks++;
      if (halted !== 1'b1 || busy !== 1'b0 || upc !== 4'd6 || mux_ctrl !== 2'd0) begin
        n_fail++; $display("FAIL halt[%0d]: halted=%b busy=%b upc=%0d ctrl=%0d, want 1 0 6 0", i, halted, busy, upc, mux_ctrl);
      end
      tick();
    end
    drive(NX, 4'd0, 1'b0, 1'b0, 1'b1);
    exp_q.push_back(4'd0);
    tick();
    exp = exp_q.pop_front();
    n_checks++;
    if (upc !== exp || halted !== 1'b0 || busy !== 1'b1) begin
      n_fail++; $display("FAIL restart: upc=%0d halted=%b busy=%b, want %0d 0 1", upc, halted, busy, exp);
    end
    // start while RUN is ignored
    drive(NX, 4'd0, 1'b0, 1'b0, 1'b1);
    exp_q.push_back(4'd1);
    tick();
    exp = exp_q.pop_front();
    n_checks++;
    if (upc !== exp) begin n_fail++; $display("FAIL start_in_run: got %0d want %0d", upc, exp); end
  endtask

  task automatic test_reset_mid_wait;
    drive(CL, 4'd3, 1'b0, 1'b0, 1'b0);
    tick();
    drive(WT, 4'd0, 1'b0, 1'b0, 1'b0);
    tick();
    n_checks++;
    if (busy !== 1'b1 || upc !== 4'd3) begin
      n_fail++; $display("FAIL pre_reset_wait: busy=%b upc=%0d, want 1 3", busy, upc);
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (upc !== 4'd0 || busy !== 1'b0 || cand_d !== 4'd0) begin
      n_fail++; $display("FAIL async_reset: upc=%0d busy=%b cand_d=%0d, want 0 0 0", upc, busy, cand_d);
    end
    @(negedge clk);
    rst_n = 1'b1;
    drive(NX, 4'd0, 1'b0, 1'b1, 1'b0);
    tick();
    n_checks++;
    if (upc !== 4'd0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL idle_after_reset: upc=%0d busy=%b, want 0 0", upc, busy);
    end
  endtask

  initial begin
    test_reset();
    test_next();
    test_branch();
    test_call_ret();
    test_wait();
    test_stack();
    test_wrap_halt();
    test_reset_mid_wait();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
